my_pipelined_barrel_shifter: RTL and testbench
==============================================

Name: my_pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter. It supports four modes: logical right, arithmetic right, logical left and rotate right. It has a valid/ready handshake on both sides and carries a tag through with each operation. It sits in the execute stage alongside the ALU and replaces the fixed 32-bit combinational right shifter, so shifts can be retimed across multiple cycles under backpressure.

Parameters:
WIDTH, 32, data width in bits; must be a power of 2, 8 to 64.
SHAMT_W, $clog2(WIDTH), shift-amount width (derived, not overridden).
PIPELINED, 1, 1 = register after every log2 stage; 0 = single output register.
TAG_W, 5, width of the passthrough tag (e.g. destination register).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  input operation valid
in_ready  out  1  block can accept an operation this cycle
in_data  in  WIDTH  operand
in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1
in_mode  in  2  00 SRL, 01 SRA, 10 SLL, 11 ROR
in_tag  in  TAG_W  opaque tag, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  WIDTH  shifted result
out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset (reset_n=0, asynchronous): all stage valid bits clear; out_valid=0, out_data=0, out_tag=0. in_ready=1 once reset_n is high.
- A transfer occurs on a rising edge with valid and ready both high, on either side.
- Stages: SHAMT_W log stages, stage k shifting by 2^(SHAMT_W-1-k) when the corresponding shamt bit is set (largest shift first).
  - PIPELINED=1: a register after each stage; latency = SHAMT_W cycles from input transfer to out_valid (5 for WIDTH=32).
  - PIPELINED=0: all stages combinational, then one register; latency 1.
- Each register slot holds valid, partial data, the remaining shamt bits, mode and tag.
- Flow control is elastic per slot:
  - A slot loads when it is empty, or when its contents move downstream this cycle.
  - in_ready = first slot will load.
  - Bubbles collapse: a stalled tail does not block upstream slots that have empty space ahead of them.
  - No combinational path from out_ready to in_ready longer than the slot chain; full throughput is 1 op/cycle with out_ready held at 1.
- Modes:
  - SRL: zero fill.
  - SRA: fill with in_data[WIDTH-1].
  - SLL: implemented by bit-reversing the operand, doing SRL, then bit-reversing the result.
  - ROR: bits shifted out at LSB re-enter at MSB.
- shamt=0 returns in_data unchanged in all modes. Values above WIDTH-1 cannot occur (width-limited).
- Ordering: results leave in strict input order; the tag always stays paired with its data.
- Stall: while out_valid=1 and out_ready=0, out_data and out_tag hold stable.
- Simultaneous events: with the pipe full and out_ready=1, in_ready=1 the same cycle; both input and output transfers complete on that edge.
- Reset mid-operation: all in-flight operations are discarded; nothing emerges after reset deasserts.
- in_valid may deassert without a transfer; the block does not latch data without a transfer.

Decomposition:
- Shared package shifter_pkg:
  - mode constants MODE_SRL=2'b00, MODE_SRA=2'b01, MODE_SLL=2'b10, MODE_ROR=2'b11;
  - function bit_reverse(WIDTH).
- One natural sub-module, my_shift_stage, parametrised by WIDTH and DIST:
  - inputs: data, enable bit, mode;
  - output: data shifted/rotated by DIST, fill chosen by mode;
  - instantiated SHAMT_W times in a generate loop, with optional register slots between instances.

Test Plan:
- Reset then single op (WIDTH=32, PIPELINED=1): in_data=0x80000001, shamt=4, SRA, tag=7 -> out_valid exactly 5 cycles later; out_data=0xF8000000, out_tag=7.
- Mode sweep on 0x80000001, shamt=1: SRL -> 0x40000000; SRA -> 0xC0000000; SLL -> 0x00000002; ROR -> 0xC0000000.
- Back-to-back 100 random ops with out_ready=1 -> one result per cycle after fill, in order, matching the reference model; shamt=0 returns the operand unchanged.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> in_ready falls after 5 accepted ops; out_data held stable; on out_ready=1 all ops drain in order with no loss or duplication.
- Reset mid-flight: 3 ops in pipe, pulse reset_n low for 1 cycle (asynchronous, mid-cycle) -> out_valid=0 immediately, and no stale result appears afterwards.
- PIPELINED=0, WIDTH=8: in_data=0x96, shamt=3, ROR -> out_data=0xD2 one cycle later.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation modes and
// the bit-reversal helper used to build left shifts from right shifts.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SRL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_SLL = 2'b10,
    MODE_ROR = 2'b11
  } shift_mode_e;

  localparam int MAX_WIDTH = 64;

  // Reverses the low `width` bits of d; bits at and above `width` return zero.
  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] d,
                                                       input int width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) r[i] = d[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/my_shift_stage.sv
// One log stage of the barrel shifter: shifts right by DIST when enabled,
// filling with zeros, the sign bit, or the bits rotated out, depending on mode.
module my_shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] shifted;

  // Left shifts arrive here bit-reversed, so they take the zero-fill path.
  always_comb begin
    case (mode)
      MODE_SRA: shifted = {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]};
      MODE_ROR: shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
      default:  shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
    endcase
  end

  assign result = enable ? shifted : data;

endmodule

// File: rtl/my_pipelined_barrel_shifter.sv
// Elastic, optionally pipelined barrel shifter (SRL/SRA/SLL/ROR) with a
// passthrough tag and valid/ready handshakes on both sides. WIDTH: power of 2, 8..64.
module my_pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int  WIDTH     = 32,
  parameter bit  PIPELINED = 1'b1,
  parameter int  TAG_W     = 5,
  localparam int SHAMT_W   = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NSLOT = PIPELINED ? SHAMT_W : 1;

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    shift_mode_e        mode;
    logic [TAG_W-1:0]   tag;
  } slot_t;

  slot_t            slot_q [NSLOT];
  slot_t            slot_d [NSLOT];
  logic [NSLOT-1:0] load;

  // Stage k shifts by 2^(SHAMT_W-1-k); its operand comes from the input port,
  // the previous slot register, or directly from the previous stage.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    logic               valid;
    logic [WIDTH-1:0]   data_in;
    logic [WIDTH-1:0]   data_out;
    logic [SHAMT_W-1:0] shamt;
    shift_mode_e        mode;
    logic [TAG_W-1:0]   tag;

    if (k == 0) begin : g_src
      assign valid   = in_valid;
      assign mode    = shift_mode_e'(in_mode);
      assign data_in = (mode == MODE_SLL)
                     ? WIDTH'(bit_reverse(MAX_WIDTH'(in_data), WIDTH)) : in_data;
      assign shamt   = in_shamt;
      assign tag     = in_tag;
    end else if (PIPELINED) begin : g_src
      assign valid   = slot_q[k-1].valid;
      assign data_in = slot_q[k-1].data;
      assign shamt   = slot_q[k-1].shamt;
      assign mode    = slot_q[k-1].mode;
      assign tag     = slot_q[k-1].tag;
    end else begin : g_src
      assign valid   = g_stage[k-1].valid;
      assign data_in = g_stage[k-1].data_out;
      assign shamt   = g_stage[k-1].shamt;
      assign mode    = g_stage[k-1].mode;
      assign tag     = g_stage[k-1].tag;
    end

    my_shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (SHAMT_W - 1 - k))
    ) u_stage (
      .data   (data_in),
      .enable (shamt[SHAMT_W-1-k]),
      .mode   (mode),
      .result (data_out)
    );

    // The last stage undoes the operand reversal for left shifts.
    if (PIPELINED || k == SHAMT_W - 1) begin : g_slot
      localparam int S = PIPELINED ? k : 0;
      assign slot_d[S] = '{
        valid: valid,
        data:  (k == SHAMT_W - 1 && mode == MODE_SLL)
               ? WIDTH'(bit_reverse(MAX_WIDTH'(data_out), WIDTH)) : data_out,
        shamt: shamt,
        mode:  mode,
        tag:   tag
      };
    end
  end

  // Ready ripples from the output back to the input: a slot loads when it is
  // empty or its contents leave this cycle, so bubbles collapse.
  // NOTE: every variable written in always_comb gets a value on all paths
  // (here a default first); otherwise synthesis infers a latch.
  always_comb begin
    logic down_ready;
    load       = '0;
    down_ready = out_ready;
    for (int s = NSLOT - 1; s >= 0; s--) begin
      load[s]    = !slot_q[s].valid || down_ready;
      down_ready = load[s];
    end
  end

  assign in_ready = load[0];

  // NOTE: sequential state uses non-blocking (<=) so every slot samples the
  // pre-edge value of its upstream neighbour; blocking here would let data
  // race through several slots in one edge.
  // NOTE: the data fields are reset too, not only the valid bits, because the
  // last slot drives out_data/out_tag, which must read zero during reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSLOT; s++) slot_q[s] <= '0;
    end else begin
      for (int s = 0; s < NSLOT; s++) begin
        if (load[s]) begin
          if (slot_d[s].valid) slot_q[s]       <= slot_d[s];
          else                 slot_q[s].valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = slot_q[NSLOT-1].valid;
  assign out_data  = slot_q[NSLOT-1].data;
  assign out_tag   = slot_q[NSLOT-1].tag;

endmodule

// File: tb/tb_my_pipelined_barrel_shifter.sv
// Directed self-checking bench: a 32-bit pipelined instance and an 8-bit
// single-register instance, with a behavioural shift model as scoreboard.
module tb_my_pipelined_barrel_shifter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, PIPELINED=1
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;

  // 8-bit, PIPELINED=0
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [2:0]  b_in_shamt;
  logic [1:0]  b_in_mode;
  logic [4:0]  b_in_tag, b_out_tag;

  int errors   = 0;
  int checks   = 0;
  int accepted = 0;

  logic [31:0] exp_d[$], got_d[$];
  logic [4:0]  exp_t[$], got_t[$];

  logic [31:0] sweep_exp [4] = '{32'h4000_0000, 32'hC000_0000, 32'h0000_0002, 32'hC000_0000};
  logic [7:0]  b_data_exp [3] = '{8'hD2, 8'hB0, 8'hF2};
  logic [1:0]  b_mode_vec [3] = '{2'b11, 2'b10, 2'b01};

  my_pipelined_barrel_shifter #(.WIDTH(32), .PIPELINED(1'b1), .TAG_W(5)) dut (
    .clock(clk), .reset_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  my_pipelined_barrel_shifter #(.WIDTH(8), .PIPELINED(1'b0), .TAG_W(5)) dut8 (
    .clock(clk), .reset_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag)
  );

  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic [1:0] m);
    case (m)
      2'b00:   return d >> s;
      2'b01:   return 32'($signed(d) >>> s);
      2'b10:   return d << s;
      default: return (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Records both handshakes at the negedge, then advances to just after the posedge.
  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready) begin
      accepted++;
      exp_d.push_back(ref_shift(in_data, in_shamt, in_mode));
      exp_t.push_back(in_tag);
    end
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_t.push_back(out_tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_d.delete(); exp_t.delete(); got_d.delete(); got_t.delete();
    accepted = 0;
  endtask

  task automatic compare_sb(input string tag);
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("%s_data[%0d]", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
      check($sformatf("%s_tag[%0d]", tag, i), 64'(got_t[i]), 64'(exp_t[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] first_data, held_d;
    logic [4:0]  held_t;

    void'($urandom(32'd11));
    in_valid = 0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0; out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_shamt = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);

    // Single SRA op: latency 5
    in_valid = 1; in_data = 32'h8000_0001; in_shamt = 5'd4; in_mode = 2'b01; in_tag = 5'd7;
    step();
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'd5);
    check("sra4_data", 64'(out_data), 64'hF800_0000);
    check("sra4_tag", 64'(out_tag), 64'd7);
    repeat (2) step();

    // Mode sweep on 0x80000001, shamt=1
    clear_sb();
    for (int m = 0; m < 4; m++) begin
      in_valid = 1; in_data = 32'h8000_0001; in_shamt = 5'd1; in_mode = 2'(m); in_tag = 5'(m + 1);
      step();
    end
    in_valid = 0;
    repeat (8) step();
    check("sweep_count", 64'(got_d.size()), 64'd4);
    for (int m = 0; m < 4 && m < got_d.size(); m++) begin
      check($sformatf("sweep_data[%0d]", m), 64'(got_d[m]), 64'(sweep_exp[m]));
      check($sformatf("sweep_tag[%0d]", m), 64'(got_t[m]), 64'(m + 1));
    end

    // 100 back-to-back random ops, out_ready held high
    clear_sb();
    first_data = 32'h0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1;
      in_data  = $urandom;
      in_shamt = (i % 10 == 0) ? 5'd0 : 5'($urandom_range(31));
      in_mode  = 2'($urandom_range(3));
      in_tag   = 5'(i);
      if (i == 0) first_data = in_data;
      step();
    end
    in_valid = 0;
    repeat (5) step();
    check("b2b_accepted", 64'(accepted), 64'd100);
    check("b2b_count", 64'(got_d.size()), 64'd100);
    if (got_d.size() > 0) check("b2b_shamt0_identity", 64'(got_d[0]), 64'(first_data));
    compare_sb("b2b");

    // Backpressure: out_ready low for 10 cycles with in_valid high
    clear_sb();
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_data  = 32'hA5C3_0F00 + 32'(accepted);
      in_shamt = 5'(accepted * 3 + 1);
      in_mode  = 2'(accepted);
      in_tag   = 5'(accepted + 10);
      step();
    end
    check("bp_accepted", 64'(accepted), 64'd5);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    held_d = out_data;
    held_t = out_tag;
    repeat (2) step();
    check("bp_hold_data", 64'(out_data), 64'(held_d));
    check("bp_hold_tag", 64'(out_tag), 64'(held_t));
    check("bp_head_data", 64'(held_d), 64'(ref_shift(32'hA5C3_0F00, 5'd1, 2'b00)));
    // Full pipe and out_ready rising: input accepted on the same edge
    in_data = 32'hA5C3_0F05; in_shamt = 5'd16; in_mode = 2'b11; in_tag = 5'd15;
    out_ready = 1;
    #2;
    check("bp_simul_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 0;
    repeat (10) step();
    check("bp_accepted_total", 64'(accepted), 64'd6);
    check("bp_count", 64'(got_d.size()), 64'd6);
    compare_sb("bp");

    // 8-bit, PIPELINED=0: one-cycle latency
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1; b_in_data = 8'h96; b_in_shamt = 3'd3; b_in_mode = b_mode_vec[i];
      b_in_tag = 5'(i + 9);
      #2;
      check($sformatf("w8_pre_valid[%0d]", i), 64'(b_out_valid), 64'd0);
      @(posedge clk); #1;
      b_in_valid = 0;
      check($sformatf("w8_valid[%0d]", i), 64'(b_out_valid), 64'd1);
      check($sformatf("w8_data[%0d]", i), 64'(b_out_data), 64'(b_data_exp[i]));
      check($sformatf("w8_tag[%0d]", i), 64'(b_out_tag), 64'(i + 9));
      @(posedge clk); #1;
    end

    // Reset mid-flight with three ops in the pipe
    clear_sb();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 32'h1111_0000 * 32'(i + 1); in_shamt = 5'(i); in_mode = 2'b00;
      in_tag = 5'(20 + i);
      step();
    end
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check("mid_out_valid_before", 64'(out_valid), 64'd1);
    #2;
    rst_n = 0;
    #1;
    check("mid_out_valid_async", 64'(out_valid), 64'd0);
    check("mid_out_data_async", 64'(out_data), 64'd0);
    check("mid_out_tag_async", 64'(out_tag), 64'd0);
    @(posedge clk); #2;
    rst_n = 1;
    out_ready = 1;
    clear_sb();
    repeat (10) step();
    check("mid_no_stale", 64'(got_d.size()), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
